// File: rtl/blake2_g_inv.sv
// Iterative inverse of the BLAKE2 G mixing function. It undoes one pair of
// G operations per cycle over four cycles, with valid/ready on both sides.
module blake2_g_inv #(
  parameter int W  = 32,
  parameter int R1 = 16,
  parameter int R2 = 12,
  parameter int R3 = 8,
  parameter int R4 = 7
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] c_o,
  output logic [W-1:0] d_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       r_state, w_next;
  logic [1:0]   r_cnt;
  logic [W-1:0] r_a, r_b, r_c, r_d, r_x, r_y;

  // Forward G ends each half with rotr(v ^ w), so undoing it rotates left
  // first and XORs afterwards. Every rotate amount is a constant, so this is wiring only.
  logic [W-1:0] w_b_r4, w_b_r2, w_d_r3, w_d_r1;
  logic [W-1:0] w_b_rot, w_d_rot, w_msg;
  logic [W-1:0] w_b_new, w_c_new, w_d_new, w_a_new;

  assign w_b_r4  = {r_b[W-R4-1:0], r_b[W-1:W-R4]};
  assign w_b_r2  = {r_b[W-R2-1:0], r_b[W-1:W-R2]};
  assign w_d_r3  = {r_d[W-R3-1:0], r_d[W-1:W-R3]};
  assign w_d_r1  = {r_d[W-R1-1:0], r_d[W-1:W-R1]};

  assign w_b_rot = r_cnt[1] ? w_b_r2 : w_b_r4;
  assign w_d_rot = r_cnt[1] ? w_d_r1 : w_d_r3;
  assign w_msg   = r_cnt[1] ? r_x    : r_y;

  // Even stages restore b then c; odd stages restore d then a.
  assign w_b_new = w_b_rot ^ r_c;
  assign w_c_new = r_c - r_d;
  assign w_d_new = w_d_rot ^ r_a;
  assign w_a_new = r_a - r_b - w_msg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) w_next = RUN;
      end
      RUN:  if (r_cnt == 2'd3) w_next = DONE;
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_d   <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (r_state == IDLE && in_valid_i) begin
      r_cnt <= '0;
      r_a   <= a_i;
      r_b   <= b_i;
      r_c   <= c_i;
      r_d   <= d_i;
      r_x   <= x_i;
      r_y   <= y_i;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 2'd1;
      if (!r_cnt[0]) begin
        r_b <= w_b_new;
        r_c <= w_c_new;
      end else begin
        r_d <= w_d_new;
        r_a <= w_a_new;
      end
    end
  end

  assign a_o = r_a;
  assign b_o = r_b;
  assign c_o = r_c;
  assign d_o = r_d;

endmodule
